// File: rtl/serial_magnitude_16_if.sv
// Handshake and result bundle for the bit-serial two's-complement to sign/magnitude decoder.
// The master issues start/operand; the slave reports busy/done and the decoded result.
interface serial_magnitude_16_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] operand;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] mag;
  logic             sign;
  logic             ovf;

  modport master (
    output start,
    output operand,
    input  busy,
    input  done,
    input  mag,
    input  sign,
    input  ovf
  );

  modport slave (
    input  start,
    input  operand,
    output busy,
    output done,
    output mag,
    output sign,
    output ovf
  );
endinterface

// File: rtl/serial_magnitude_16.sv
// Bit-serial two's-complement to sign + magnitude decoder, LSB first, one bit per clock.
// Negative operands use copy-until-first-one-then-invert; results publish on entry to FIN.
module serial_magnitude_16 #(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_magnitude_16_if.slave bus
);
  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] mag_r;
  logic             neg;
  logic             seen_one;
  logic             sign_r;
  logic             ovf_r;
  logic             out_bit;
  logic [CW-1:0]    count;

  function automatic logic decode_bit(input logic b, input logic negative, input logic seen);
    return negative ? (b ^ seen) : b;
  endfunction

  assign out_bit     = decode_bit(shift_reg[0], neg, seen_one);
  assign result_next = {out_bit, result_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FIN accepts a new request exactly like IDLE so back-to-back runs have no gap
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (count == LAST) state_next = FIN;
      end
      FIN: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      result_reg <= '0;
      neg        <= 1'b0;
      seen_one   <= 1'b0;
      count      <= '0;
      mag_r      <= '0;
      sign_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else if (accept) begin
      shift_reg <= bus.operand;
      neg       <= bus.operand[WIDTH-1];
      seen_one  <= 1'b0;
      count     <= '0;
    end else if (state == SHIFT) begin
      shift_reg  <= shift_reg >> 1;
      seen_one   <= seen_one | shift_reg[0];
      result_reg <= result_next;
      count      <= count + CW'(1);
      if (count == LAST) begin
        mag_r  <= result_next;
        sign_r <= neg;
        // A negative operand decodes to 2^(WIDTH-1) only when it was the most negative value
        ovf_r  <= neg && (result_next == MOST_NEG);
      end
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == FIN);
  assign bus.mag  = mag_r;
  assign bus.sign = sign_r;
  assign bus.ovf  = ovf_r;
endmodule
